confreg_bridge: RTL and testbench

CONFREG_BRIDGE -- requirements
Module: confreg_bridge

---
 rtl/confreg_bridge.sv | 138 +++++++++++++
 tb/tb_confreg_bridge.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/confreg_bridge.sv
// CPU data-port bridge: steers sram-like requests to the confreg window or to RAM,
// with one transaction in flight and a RAM response timeout that raises a sticky bus_err.
module confreg_bridge #(
  parameter logic [15:0] CONF_HI = 16'hbfaf,
  parameter int unsigned TMO     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic        conf_en,
  output logic [3:0]  conf_wen,
  output logic [31:0] conf_addr,
  output logic [31:0] conf_wdata,
  input  logic [31:0] conf_rdata,
  output logic        ram_req,
  output logic        ram_wr,
  output logic [1:0]  ram_size,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic        ram_addr_ok,
  input  logic        ram_data_ok,
  input  logic [31:0] ram_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, CONF_RSP, RAM_WAIT} state_t;

  localparam logic [7:0] TMO_C = 8'(TMO);

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;
  logic        conf_sel;
  logic        misaligned;
  logic [3:0]  wen_mask;

  assign conf_sel   = (cpu_addr[31:16] == CONF_HI);
  assign conf_addr  = cpu_addr;
  assign conf_wdata = cpu_wdata;
  assign ram_wr     = cpu_wr;
  assign ram_size   = cpu_size;
  assign ram_addr   = cpu_addr;
  assign ram_wdata  = cpu_wdata;
  assign bus_err    = bus_err_q;

  // Size 3 is treated as a word access.
  always_comb begin
    wen_mask   = 4'b0000;
    misaligned = 1'b0;
    case (cpu_size)
      2'd0: wen_mask = 4'b0001 << cpu_addr[1:0];
      2'd1: begin
        misaligned = cpu_addr[0];
        wen_mask   = cpu_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        misaligned = |cpu_addr[1:0];
        wen_mask   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    bus_err_d   = bus_err_q;
    cpu_addr_ok = 1'b0;
    cpu_data_ok = 1'b0;
    cpu_rdata   = rdata_q;
    conf_en     = 1'b0;
    conf_wen    = 4'b0000;
    ram_req     = 1'b0;
    case (state_q)
      IDLE: begin
        if (conf_sel) begin
          cpu_addr_ok = 1'b1;
          if (cpu_req) begin
            conf_en  = 1'b1;
            conf_wen = (cpu_wr && !misaligned) ? wen_mask : 4'b0000;
            rdata_d  = conf_rdata;
            state_d  = CONF_RSP;
          end
        end else begin
          ram_req     = cpu_req;
          cpu_addr_ok = ram_addr_ok;
          if (cpu_req && ram_addr_ok) begin
            cnt_d   = 8'd0;
            state_d = RAM_WAIT;
          end
        end
      end
      CONF_RSP: begin
        cpu_data_ok = 1'b1;
        state_d     = IDLE;
      end
      RAM_WAIT: begin
        cpu_rdata = ram_rdata;
        // A response landing on the timeout cycle wins over the timeout.
        if (ram_data_ok) begin
          cpu_data_ok = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q == TMO_C) begin
          cpu_data_ok = 1'b1;
          cpu_rdata   = 32'h0;
          bus_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rdata_q   <= 32'h0;
      cnt_q     <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_confreg_bridge.sv
// Self-checking bench for confreg_bridge: directed scenarios plus randomized
// transactions checked against a transaction-level model.
module tb_confreg_bridge;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wr;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        conf_en;
  logic [3:0]  conf_wen;
  logic [31:0] conf_addr, conf_wdata, conf_rdata;
  logic        ram_req, ram_wr;
  logic [1:0]  ram_size;
  logic [31:0] ram_addr, ram_wdata;
  logic        ram_addr_ok, ram_data_ok;
  logic [31:0] ram_rdata;
  logic        bus_err;

  int   n_chk  = 0;
  int   n_pass = 0;
  logic exp_err;

  confreg_bridge #(.CONF_HI(16'hbfaf), .TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .conf_en(conf_en), .conf_wen(conf_wen), .conf_addr(conf_addr),
    .conf_wdata(conf_wdata), .conf_rdata(conf_rdata),
    .ram_req(ram_req), .ram_wr(ram_wr), .ram_size(ram_size),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_addr_ok(ram_addr_ok), .ram_data_ok(ram_data_ok), .ram_rdata(ram_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Byte-lane mask from access width and offset; misaligned or read -> no lanes.
  function automatic logic [3:0] model_wen(input logic wr, input logic [1:0] size,
                                           input logic [31:0] addr);
    int nbytes, off;
    if (!wr) return 4'b0000;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off    = int'(addr[1:0]);
    if (off % nbytes != 0) return 4'b0000;
    return 4'(((1 << nbytes) - 1) << off);
  endfunction

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic conf_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] crd);
    cpu_req = 1'b1; cpu_wr = wr; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
    conf_rdata = crd;
    @(negedge clk);
    check("conf_aok", cpu_addr_ok, 1);
    check("conf_en", conf_en, 1);
    check("conf_wen", conf_wen, model_wen(wr, size, addr));
    check("conf_addr", conf_addr, addr);
    check("conf_wdata", conf_wdata, wdata);
    check("conf_ram_req", ram_req, 0);
    check("conf_dok_early", cpu_data_ok, 0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    conf_rdata = $urandom;
    @(negedge clk);
    check("conf_dok", cpu_data_ok, 1);
    check("conf_rdata", cpu_rdata, crd);
    check("conf_rsp_aok", cpu_addr_ok, 0);
    check("conf_rsp_en", conf_en, 0);
    check("conf_rsp_wen", conf_wen, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("conf_dok_once", cpu_data_ok, 0);
    @(posedge clk); #1;
  endtask

  // d_a: cycles ram_addr_ok held low; d_d: wait-cycle index of ram_data_ok (> TMO = never).
  task automatic ram_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int d_a, input int d_d,
                         input logic [31:0] rd);
    int          exp_idx;
    logic [31:0] exp_rd;
    logic        timed_out;
    timed_out = (d_d > TMO);
    exp_idx   = timed_out ? TMO : d_d;
    exp_rd    = timed_out ? 32'h0 : rd;
    cpu_req = 1'b1; cpu_wr = wr; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
    ram_addr_ok = 1'b0; ram_data_ok = 1'b0;
    for (int i = 0; i < d_a; i++) begin
      @(negedge clk);
      check("ram_req_hold", ram_req, 1);
      check("ram_aok_low", cpu_addr_ok, 0);
      check("ram_conf_en", conf_en, 0);
      @(posedge clk); #1;
    end
    ram_addr_ok = 1'b1;
    @(negedge clk);
    check("ram_aok", cpu_addr_ok, 1);
    check("ram_req", ram_req, 1);
    check("ram_addr", ram_addr, addr);
    check("ram_wr", ram_wr, wr);
    check("ram_size", ram_size, size);
    check("ram_wdata", ram_wdata, wdata);
    check("ram_hs_conf_en", conf_en, 0);
    @(posedge clk); #1;
    cpu_req = 1'b0; ram_addr_ok = 1'b0;
    for (int k = 0; k <= TMO; k++) begin
      ram_data_ok = (k == d_d);
      ram_rdata   = (k == d_d) ? rd : $urandom;
      @(negedge clk);
      check("wait_ram_req", ram_req, 0);
      if (k == exp_idx) begin
        check("ram_dok", cpu_data_ok, 1);
        check("ram_rdata", cpu_rdata, exp_rd);
        check("ram_wait_conf_en", conf_en, 0);
      end else begin
        check("ram_dok_early", cpu_data_ok, 0);
      end
      @(posedge clk); #1;
      if (k == exp_idx) break;
    end
    ram_data_ok = 1'b0;
    if (timed_out) begin
      exp_err = 1'b1;
      ram_data_ok = 1'b1;
      ram_rdata = 32'hdead_beef;
      @(negedge clk);
      check("late_dok_ignored", cpu_data_ok, 0);
      @(posedge clk); #1;
      ram_data_ok = 1'b0;
    end
    @(negedge clk);
    check("bus_err", bus_err, exp_err);
    check("ram_dok_once", cpu_data_ok, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a, wd, rd;
    logic        wr;
    logic [1:0]  sz;
    int          sel, dd;

    reset = 1'b0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_size = 2'd0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    conf_rdata = 32'h0; ram_addr_ok = 1'b0; ram_data_ok = 1'b0; ram_rdata = 32'h0;
    exp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dok", cpu_data_ok, 0);
    check("rst_conf_en", conf_en, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_ram_req", ram_req, 0);
    reset = 1'b1;

    // First edge after release must already accept.
    conf_txn(1'b0, 2'd2, 32'hbfaf_f000, 32'h0, 32'h0000_a5a5);
    conf_txn(1'b1, 2'd0, 32'hbfaf_f002, 32'h00ff_0000, 32'h1111_2222);
    conf_txn(1'b1, 2'd1, 32'hbfaf_f001, 32'hcafe_f00d, 32'h3333_4444);
    ram_txn(1'b0, 2'd2, 32'h8000_0100, 32'h0, 2, 2, 32'h1234_5678);
    ram_txn(1'b0, 2'd2, 32'h8000_0200, 32'h0, 0, TMO + 100, 32'h0);

    // Reset in RAM_WAIT abandons the transaction and clears bus_err.
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h8000_0300;
    ram_addr_ok = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0; ram_addr_ok = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rw_dok_low", cpu_data_ok, 0);
      @(posedge clk); #1;
    end
    check("pre_rst_bus_err", bus_err, exp_err);
    reset = 1'b0;
    exp_err = 1'b0;
    #1;
    check("arst_bus_err", bus_err, 0);
    check("arst_dok", cpu_data_ok, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ram_data_ok = (i == 1);
      ram_rdata = 32'h5555_aaaa;
      @(negedge clk);
      check("post_rst_dok", cpu_data_ok, 0);
      check("post_rst_err", bus_err, 0);
      @(posedge clk); #1;
    end
    ram_data_ok = 1'b0;
    conf_txn(1'b0, 2'd2, 32'hbfaf_f010, 32'h0, 32'h0bad_cafe);

    for (int t = 0; t < 40; t++) begin
      a  = $urandom;
      wd = $urandom;
      rd = $urandom;
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        a[31:16] = 16'hbfaf;
        conf_txn(wr, sz, a, wd, rd);
      end else begin
        if (a[31:16] == 16'hbfaf) a[31] = ~a[31];
        sel = $urandom_range(0, 11);
        dd  = (sel < 8) ? sel : (sel == 8) ? TMO : (sel == 9) ? TMO - 1 : TMO + 5;
        ram_txn(wr, sz, a, wd, $urandom_range(0, 3), dd, rd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
